// File: rtl/mfcc_pkg.sv
// Shared widths and FSM encoding for the mel-filterbank channel.
package mfcc_pkg;
  localparam int ADDR_WIDTH_D = 9;
  localparam int COEF_W_D     = 8;
  localparam int PWR_W_D      = 32;
  localparam int ACC_W_D      = 48;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
endpackage

// File: rtl/mfcc_mel_mac.sv
// Weight-and-accumulate datapath: optional ROM-align stage, product register, accumulator.
// MFCC_MEL_SAT_EN selects a saturating accumulator; otherwise the sum wraps.
module mfcc_mel_mac
  import mfcc_pkg::*;
#(
  parameter int PWR_W   = PWR_W_D,
  parameter int COEF_W  = COEF_W_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int ROM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic              i_first,
  input  logic              i_last,
  input  logic [PWR_W-1:0]  i_data,
  input  logic [COEF_W-1:0] i_coef,
  output logic              o_fin,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);
  localparam int PROD_W = PWR_W + COEF_W;

  logic              w_m_vld, w_m_first, w_m_last;
  logic [PWR_W-1:0]  w_m_data;
  logic              r_p_vld, r_p_first, r_p_last;
  logic [PROD_W-1:0] r_prod;
  logic [ACC_W-1:0]  r_acc, w_sum, w_prod_ext;

  // A registered ROM returns the weight one cycle late, so the bin is held back to meet it.
  generate
    if (ROM_LAT == 1) begin : g_align
      logic             r_a_vld, r_a_first, r_a_last;
      logic [PWR_W-1:0] r_a_data;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a_vld   <= 1'b0;
          r_a_first <= 1'b0;
          r_a_last  <= 1'b0;
          r_a_data  <= '0;
        end else begin
          r_a_vld   <= i_vld;
          r_a_first <= i_first;
          r_a_last  <= i_last;
          r_a_data  <= i_data;
        end
      end
      assign w_m_vld   = r_a_vld;
      assign w_m_first = r_a_first;
      assign w_m_last  = r_a_last;
      assign w_m_data  = r_a_data;
    end else begin : g_noalign
      assign w_m_vld   = i_vld;
      assign w_m_first = i_first;
      assign w_m_last  = i_last;
      assign w_m_data  = i_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_vld   <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_prod    <= '0;
    end else begin
      r_p_vld   <= w_m_vld;
      r_p_first <= w_m_first;
      r_p_last  <= w_m_last;
      if (w_m_vld) r_prod <= PROD_W'(w_m_data) * PROD_W'(i_coef);
    end
  end

  assign w_prod_ext = ACC_W'(r_prod);

`ifdef MFCC_MEL_SAT_EN
  logic [ACC_W:0] w_add;
  logic           r_sat, w_sat;
  assign w_add = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_sum = r_p_first ? w_prod_ext : (w_add[ACC_W] ? '1 : w_add[ACC_W-1:0]);
  assign w_sat = r_p_first ? 1'b0 : (r_sat | w_add[ACC_W]);
  always_ff @(posedge clk) begin
    if (!rst_n)       r_sat <= 1'b0;
    else if (r_p_vld) r_sat <= w_sat;
  end
  assign o_sat = w_sat;
`else
  assign w_sum = r_p_first ? w_prod_ext : r_acc + w_prod_ext;
  assign o_sat = 1'b0;
`endif

  // First product of a frame overwrites the accumulator, so no clear cycle is needed.
  always_ff @(posedge clk) begin
    if (!rst_n)       r_acc <= '0;
    else if (r_p_vld) r_acc <= w_sum;
  end

  assign o_fin = r_p_vld & r_p_last;
  assign o_sum = w_sum;
endmodule

// File: rtl/mfcc_mel_filter_chan.sv
// One mel filter: walks the coefficient ROM by bin index, accumulates weighted power, emits one energy per frame.
// MFCC_MEL_SAT_EN enables accumulator saturation and the m_sat flag.
module mfcc_mel_filter_chan
  import mfcc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int COEF_W     = COEF_W_D,
  parameter int PWR_W      = PWR_W_D,
  parameter int ACC_W      = ACC_W_D,
  parameter int ROM_LAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PWR_W-1:0]      s_data,
  input  logic                  s_last,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COEF_W-1:0]     rom_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ACC_W-1:0]      m_data,
  output logic                  m_trunc,
  output logic                  m_sat
);
  state_e                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_bin_cnt;
  logic                  r_s_ready, r_trunc_pend;
  logic [ACC_W-1:0]      r_m_data;
  logic                  r_m_trunc, r_m_sat;
  logic                  w_acc, w_last_eff, w_first, w_fin, w_sat, w_load;
  logic [ACC_W-1:0]      w_sum;

  assign w_acc      = s_valid & r_s_ready;
  // The final ROM address closes the frame even without s_last.
  assign w_last_eff = s_last | (&r_bin_cnt);
  assign w_first    = w_acc & (r_state == IDLE);
  assign w_load     = (r_state == FLUSH) & w_fin;

  mfcc_mel_mac #(
    .PWR_W  (PWR_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .ROM_LAT(ROM_LAT)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_acc),
    .i_first(w_first),
    .i_last (w_acc & w_last_eff),
    .i_data (s_data),
    .i_coef (rom_data),
    .o_fin  (w_fin),
    .o_sum  (w_sum),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = w_last_eff ? FLUSH : RUN;
      RUN:     if (w_acc && w_last_eff) w_state_nxt = FLUSH;
      FLUSH:   if (w_fin) w_state_nxt = DONE;
      DONE:    if (m_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_ready    <= 1'b0;
      r_bin_cnt    <= '0;
      r_trunc_pend <= 1'b0;
      r_m_data     <= '0;
      r_m_trunc    <= 1'b0;
      r_m_sat      <= 1'b0;
    end else begin
      r_s_ready <= (w_state_nxt == IDLE) || (w_state_nxt == RUN);
      if (w_acc) begin
        r_bin_cnt <= w_last_eff ? '0 : r_bin_cnt + 1'b1;
        if (w_last_eff) r_trunc_pend <= ~s_last;
      end
      // Capture the final sum straight off the adder as the last product retires.
      if (w_load) begin
        r_m_data  <= w_sum;
        r_m_trunc <= r_trunc_pend;
        r_m_sat   <= w_sat;
      end
    end
  end

  assign s_ready  = r_s_ready;
  assign rom_addr = r_bin_cnt;
  assign m_valid  = (r_state == DONE);
  assign m_data   = r_m_data;
  assign m_trunc  = r_m_trunc;
  assign m_sat    = r_m_sat;
endmodule
